// File: rtl/serial_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state type and default operand width.
package cmp_pkg;

  localparam int unsigned CMP_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_e;

endpackage

// File: rtl/serial_comparator_if.sv
// Bit-serial operand stream and result bundle between a driver (master) and the comparator (slave).
interface serial_comparator_if;

  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic bit_ready;
  logic busy;
  logic done;
  logic eq;
  logic gt;
  logic lt;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  bit_ready, busy, done, eq, gt, lt
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output bit_ready, busy, done, eq, gt, lt
  );

endinterface

// File: rtl/serial_comparator_equal.sv
// 1-bit equality cell used for each serial operand bit pair.
module equal (
  input  logic a,
  input  logic b,
  output logic eq
);

  assign eq = (a & b) | (~a & ~b);

endmodule

// File: rtl/serial_comparator.sv
// MSB-first serial comparator: consumes WIDTH bit pairs and reports A==B, A>B or A<B with a done pulse.
module serial_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = CMP_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  serial_comparator_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  cmp_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             bit_eq;

  equal u_equal (
    .a  (bus.a_bit),
    .b  (bus.b_bit),
    .eq (bit_eq)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          cnt_d     = '0;
          decided_d = 1'b0;
          eq_d      = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (bus.bit_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          // MSB-first: the first differing pair alone decides the magnitude order.
          if (!decided_q && !bit_eq) begin
            decided_d = 1'b1;
            gt_d      = bus.a_bit & ~bus.b_bit;
            lt_d      = ~bus.a_bit & bus.b_bit;
          end
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            eq_d    = ~decided_d;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates so every flop samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  assign bus.bit_ready = (state_q == SHIFT);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = (state_q == DONE);
  assign bus.eq        = eq_q;
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 The module SHALL take parameter WIDTH, default 8, as the number of operand bits per comparison (legal range 2..64).
REQ-002 The module SHALL have input clk, 1 bit, as the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have input rst, 1 bit, as the reset, which is synchronous and active-high.
REQ-004 The module SHALL have input start, 1 bit, as the request to begin a new comparison.
REQ-005 The module SHALL have input bit_valid, 1 bit, which qualifies a_bit/b_bit.
REQ-006 The module SHALL have inputs a_bit and b_bit, 1 bit each, carrying operand bits MSB-first.
REQ-007 The module SHALL have output bit_ready, 1 bit, high when an operand bit pair can be accepted.
REQ-008 The module SHALL have output busy, 1 bit, high while a comparison is in progress.
REQ-009 The module SHALL have output done, 1 bit, a one-cycle pulse that marks a valid result.
REQ-010 The module SHALL have outputs eq, gt and lt, 1 bit each, as registered results for A==B, A>B and A<B.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and DONE and SHALL be encoded in 2 bits.
REQ-012 In IDLE or DONE, start=1 SHALL move the FSM to SHIFT on the next edge, clear the bit counter, set a decided flag to 0 and clear eq/gt/lt.
REQ-013 In SHIFT, start SHALL be ignored; a running comparison is never restarted except by rst.
REQ-014 bit_ready SHALL be 1 exactly when the state is SHIFT; busy SHALL equal bit_ready.
REQ-015 A bit pair SHALL be accepted only on an edge where bit_valid=1 and bit_ready=1; bit_valid=0 stalls with all state held.
REQ-016 Per accepted pair, bit equality SHALL be computed by the 1-bit equality cell (eq = a&b | ~a&~b).
REQ-017 While decided=0, the first accepted pair with inequal bits SHALL set decided=1 and latch gt=a_bit&~b_bit and lt=~a_bit&b_bit.
REQ-018 Once decided=1, later pairs SHALL be consumed but SHALL NOT change gt/lt.
REQ-019 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL increment per accepted pair.
REQ-020 When the WIDTH-th pair is accepted, the FSM SHALL enter DONE on that edge, with eq=~decided_next and gt/lt final.
REQ-021 done SHALL be 1 for exactly the one cycle spent in DONE; without start, DONE SHALL return to IDLE on the next edge.
REQ-022 Result latency SHALL be: start edge, then WIDTH accepted pairs, then done in the cycle following the last acceptance; the minimum is WIDTH+1 cycles after the start edge.
REQ-023 eq, gt and lt SHALL be mutually exclusive whenever done=1, and SHALL hold their values in IDLE until the next accepted start.
REQ-024 start asserted in DONE SHALL be accepted (back-to-back), with done still pulsing in that cycle.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE and clear counter, decided, eq, gt, lt and done to 0, including mid-comparison; rst has priority over start and bit_valid.
REQ-026 After reset, bit_ready=0, busy=0 and done=0 until a start is accepted.

Structure
REQ-027 A shared package cmp_pkg SHALL hold the FSM state typedef (IDLE=0, SHIFT=1, DONE=2) and the default-width constant.
REQ-028 The per-bit equality SHALL be a single instance of the existing 1-bit cell equal; there SHALL be no other sub-modules.

Verification
REQ-029 WIDTH=8, A=0xA5, B=0xA5, bit_valid always 1 -> done exactly 9 cycles after the start edge, eq=1, gt=0, lt=0.
REQ-030 A=0x80, B=0x7F -> decided on the first bit, all 8 bits consumed, done with gt=1, lt=0, eq=0.
REQ-031 A=0x12, B=0x13, with bit_valid low for 3 cycles after bit 4 -> done delayed 3 cycles, lt=1.
REQ-032 rst pulsed after bit 5 of a comparison -> next cycle IDLE, all outputs 0; a fresh compare of 0xFF vs 0x00 gives gt=1.
REQ-033 start held high continuously, two compares back-to-back (0x01 vs 0x02, then 0x02 vs 0x01) -> done pulses 9 cycles apart with lt then gt; start during SHIFT has no effect.
REQ-034 Random A/B over 10,000 compares at WIDTH=8 and 16 with random bit_valid gaps -> results match a reference model, exactly one of eq/gt/lt is set at each done, and done is never wider than one cycle.
